// File: rtl/sdram_client_responder.sv
// Client-side SDRAM word sequencer: serves one client read/write per core handshake
// and hands the core port to the display path when the client yields.
module sdram_client_responder #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [1:0]        i_Command,
  input  logic [ADDR_W-1:0] i_Data_Address,
  input  logic [DATA_W-1:0] i_Data_Write,
  output logic [DATA_W-1:0] o_Data_Read,
  output logic              o_Data_Read_Valid,
  output logic              o_Data_Write_Done,
  output logic              o_SDRAM_Requested,
  input  logic              i_SDRAM_Yield,
  output logic              o_Core_Req,
  output logic              o_Core_We,
  output logic [ADDR_W-1:0] o_Core_Addr,
  output logic [DATA_W-1:0] o_Core_Wdata,
  input  logic              i_Core_Ack,
  input  logic [DATA_W-1:0] i_Core_Rdata,
  input  logic              i_Display_Need,
  output logic              o_Display_Grant,
  input  logic              i_Display_Done
);

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DISP} state_t;

  state_t state, state_next;
  logic   pend;
  logic   cmd_valid_c;
  logic   issue_ack_c;
  logic   enter_issue_c;
  logic   enter_disp_c;

  assign o_SDRAM_Requested = pend;

  // State register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next state; encoding 2'b11 behaves as idle
  always_comb begin
    state_next    = state;
    cmd_valid_c   = (i_Command == CMD_READ) || (i_Command == CMD_WRITE);
    issue_ack_c   = 1'b0;
    enter_issue_c = 1'b0;
    enter_disp_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend && i_SDRAM_Yield) begin
          state_next   = S_DISP;
          enter_disp_c = 1'b1;
        end else if (cmd_valid_c) begin
          state_next    = S_ISSUE;
          enter_issue_c = 1'b1;
        end
      end
      S_ISSUE: begin
        if (i_Core_Ack) begin
          state_next  = S_GAP;
          issue_ack_c = 1'b1;
        end
      end
      S_GAP:   state_next = S_IDLE;
      S_DISP:  if (i_Display_Done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs, command latch and display-pending flag
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pend              <= 1'b0;
      o_Core_Req        <= 1'b0;
      o_Core_We         <= 1'b0;
      o_Core_Addr       <= '0;
      o_Core_Wdata      <= '0;
      o_Data_Read       <= '0;
      o_Data_Read_Valid <= 1'b0;
      o_Data_Write_Done <= 1'b0;
      o_Display_Grant   <= 1'b0;
    end else begin
      o_Core_Req        <= (state_next == S_ISSUE);
      o_Display_Grant   <= (state_next == S_DISP);
      o_Data_Read_Valid <= issue_ack_c && !o_Core_We;
      o_Data_Write_Done <= issue_ack_c && o_Core_We;
      if (issue_ack_c && !o_Core_We) o_Data_Read <= i_Core_Rdata;
      if (enter_issue_c) begin
        o_Core_Addr  <= i_Data_Address;
        o_Core_Wdata <= i_Data_Write;
        o_Core_We    <= (i_Command == CMD_WRITE);
      end
      if (enter_disp_c)                          pend <= 1'b0;
      else if (i_Display_Need && state != S_DISP) pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_client_responder.sv
// Self-checking bench for sdram_client_responder: directed scenarios plus a randomized
// word stream checked against a word-level memory model of the client/core exchange.
module tb_sdram_client_responder;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 32;
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  logic              i_Clk = 1'b0;
  logic              i_Reset;
  logic [1:0]        i_Command;
  logic [ADDR_W-1:0] i_Data_Address;
  logic [DATA_W-1:0] i_Data_Write;
  logic [DATA_W-1:0] o_Data_Read;
  logic              o_Data_Read_Valid;
  logic              o_Data_Write_Done;
  logic              o_SDRAM_Requested;
  logic              i_SDRAM_Yield;
  logic              o_Core_Req;
  logic              o_Core_We;
  logic [ADDR_W-1:0] o_Core_Addr;
  logic [DATA_W-1:0] o_Core_Wdata;
  logic              i_Core_Ack;
  logic [DATA_W-1:0] i_Core_Rdata;
  logic              i_Display_Need;
  logic              o_Display_Grant;
  logic              i_Display_Done;

  sdram_client_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Command(i_Command),
    .i_Data_Address(i_Data_Address), .i_Data_Write(i_Data_Write),
    .o_Data_Read(o_Data_Read), .o_Data_Read_Valid(o_Data_Read_Valid),
    .o_Data_Write_Done(o_Data_Write_Done), .o_SDRAM_Requested(o_SDRAM_Requested),
    .i_SDRAM_Yield(i_SDRAM_Yield), .o_Core_Req(o_Core_Req), .o_Core_We(o_Core_We),
    .o_Core_Addr(o_Core_Addr), .o_Core_Wdata(o_Core_Wdata), .i_Core_Ack(i_Core_Ack),
    .i_Core_Rdata(i_Core_Rdata), .i_Display_Need(i_Display_Need),
    .o_Display_Grant(o_Display_Grant), .i_Display_Done(i_Display_Done)
  );

  always #5 i_Clk = ~i_Clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] last_read = '0;

  // Core-side memory model; unwritten words have a fixed address-derived pattern
  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {10'h2A5, a} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(negedge i_Clk);
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Command = CMD_IDLE; i_Data_Address = '0; i_Data_Write = '0;
    i_SDRAM_Yield = 1'b0; i_Core_Ack = 1'b0; i_Core_Rdata = '0;
    i_Display_Need = 1'b0; i_Display_Done = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({o_Core_Req, o_Core_We, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Display_Grant} !== 6'b0)
      $display("FAIL reset_ctrl got=%b want=000000", {o_Core_Req, o_Core_We, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Display_Grant});
    else n_pass++;
    n_checks++;
    if ({o_Data_Read, o_Core_Addr, o_Core_Wdata} !== '0)
      $display("FAIL reset_data got rd=%h addr=%h wd=%h want 0", o_Data_Read, o_Core_Addr, o_Core_Wdata);
    else n_pass++;
    i_Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    i_Command = CMD_READ; i_Data_Address = 22'h000010; i_Data_Write = 32'h0BAD_F00D;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Core_We, o_Core_Addr} !== {1'b1, 1'b0, 22'h000010})
      $display("FAIL rd_issue got req=%b we=%b addr=%h want 1 0 000010", o_Core_Req, o_Core_We, o_Core_Addr);
    else n_pass++;
    i_Command = CMD_IDLE; i_Data_Address = 22'h000003;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Data_Read_Valid, o_Core_Addr} !== {1'b1, 1'b0, 22'h000010})
      $display("FAIL rd_wait got req=%b valid=%b addr=%h want 1 0 000010", o_Core_Req, o_Data_Read_Valid, o_Core_Addr);
    else n_pass++;
    tick();
    i_Core_Ack = 1'b1; i_Core_Rdata = 32'hDEADBEEF;
    tick();
    i_Core_Ack = 1'b0; i_Core_Rdata = $urandom;
    n_checks++;
    if ({o_Data_Read_Valid, o_Core_Req, o_Data_Read} !== {1'b1, 1'b0, 32'hDEADBEEF})
      $display("FAIL rd_done got valid=%b req=%b data=%h want 1 0 deadbeef", o_Data_Read_Valid, o_Core_Req, o_Data_Read);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_Data_Read_Valid, o_Data_Read} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL rd_hold got valid=%b data=%h want 0 deadbeef", o_Data_Read_Valid, o_Data_Read);
    else n_pass++;
    last_read = 32'hDEADBEEF;
  endtask

  task automatic test_write_burst();
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] wd [8];
    int writes = 0;
    int dones  = 0;
    base = 22'(24'h000100 + 24'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) wd[k] = $urandom;
    i_Command = CMD_WRITE; i_Data_Address = base; i_Data_Write = wd[0];
    for (int c = 0; c < 80 && dones < 8; c++) begin
      tick();
      i_Core_Ack = 1'b0;
      if (o_Data_Write_Done) begin
        dones++;
        n_checks++;
        if (o_Core_Req !== 1'b0) $display("FAIL wb_gap_req word=%0d got=%b want=0", dones, o_Core_Req);
        else n_pass++;
        if (dones < 8) begin
          i_Data_Address = 22'(base + 22'(dones)); i_Data_Write = wd[dones];
        end else i_Command = CMD_IDLE;
      end else if (o_Core_Req) begin
        n_checks++;
        if ({o_Core_We, o_Core_Addr, o_Core_Wdata} !== {1'b1, 22'(base + 22'(writes)), wd[writes % 8]})
          $display("FAIL wb_core word=%0d got we=%b addr=%h wd=%h want 1 %h %h", writes, o_Core_We,
                   o_Core_Addr, o_Core_Wdata, 22'(base + 22'(writes)), wd[writes % 8]);
        else n_pass++;
        mem[o_Core_Addr] = o_Core_Wdata;
        writes++;
        i_Core_Ack = 1'b1;
      end
    end
    repeat (2) tick();
    n_checks++;
    if (dones !== 8 || writes !== 8 || o_Core_Req !== 1'b0)
      $display("FAIL wb_count got dones=%0d writes=%0d req=%b want 8 8 0", dones, writes, o_Core_Req);
    else n_pass++;
  endtask

  task automatic test_display_mid_burst();
    logic [ADDR_W-1:0] base;
    int rd = 0;
    int wait_c = 0;
    int raise_c = -10;
    bit raised = 1'b0;
    base = 22'($urandom_range(0, 7));
    i_Command = CMD_READ; i_Data_Address = base;
    for (int c = 0; c < 60 && rd < 4; c++) begin
      tick();
      i_Core_Ack = 1'b0;
      n_checks++;
      if (o_Display_Grant !== 1'b0) $display("FAIL dm_grant_early cyc=%0d got=%b want=0", c, o_Display_Grant);
      else n_pass++;
      if (raised && c == raise_c + 1) begin
        n_checks++;
        if ({o_SDRAM_Requested, o_Core_Req} !== 2'b11)
          $display("FAIL dm_requested got req_flag=%b core_req=%b want 1 1", o_SDRAM_Requested, o_Core_Req);
        else n_pass++;
      end
      if (o_Data_Read_Valid) begin
        n_checks++;
        if (o_Data_Read !== mem_rd(22'(base + 22'(rd))))
          $display("FAIL dm_rdata word=%0d got=%h want=%h", rd, o_Data_Read, mem_rd(22'(base + 22'(rd))));
        else n_pass++;
        last_read = mem_rd(22'(base + 22'(rd)));
        rd++;
        if (rd < 4) i_Data_Address = 22'(base + 22'(rd));
        else begin i_Command = CMD_IDLE; i_SDRAM_Yield = 1'b1; end
      end
      if (o_Core_Req) begin
        if (!raised) begin i_Display_Need = 1'b1; raised = 1'b1; raise_c = c; end
        if (wait_c == 1) begin
          i_Core_Ack = 1'b1; i_Core_Rdata = mem_rd(o_Core_Addr); wait_c = 0;
        end else wait_c++;
      end
    end
    n_checks++;
    if (rd !== 4) $display("FAIL dm_burst got=%0d want=4", rd);
    else n_pass++;
    tick();
    n_checks++;
    if (o_Display_Grant !== 1'b0) $display("FAIL dm_grant_gap got=%b want=0", o_Display_Grant);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_Display_Grant, o_SDRAM_Requested, o_Core_Req} !== 3'b100)
      $display("FAIL dm_disp got grant=%b reqflag=%b core_req=%b want 1 0 0", o_Display_Grant, o_SDRAM_Requested, o_Core_Req);
    else n_pass++;
    i_Display_Need = 1'b0; i_SDRAM_Yield = 1'b0;
    i_Command = CMD_READ; i_Data_Address = 22'h3FFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({o_Display_Grant, o_Core_Req} !== 2'b10)
        $display("FAIL dm_hold cyc=%0d got grant=%b req=%b want 1 0", c, o_Display_Grant, o_Core_Req);
      else n_pass++;
    end
    i_Display_Done = 1'b1;
    tick();
    i_Display_Done = 1'b0;
    n_checks++;
    if ({o_Display_Grant, o_Core_Req} !== 2'b00)
      $display("FAIL dm_release got grant=%b req=%b want 0 0", o_Display_Grant, o_Core_Req);
    else n_pass++;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Core_We, o_Core_Addr} !== {1'b1, 1'b0, 22'h3FFFFF})
      $display("FAIL dm_resume got req=%b we=%b addr=%h want 1 0 3fffff", o_Core_Req, o_Core_We, o_Core_Addr);
    else n_pass++;
    i_Core_Ack = 1'b1; i_Core_Rdata = mem_rd(22'h3FFFFF);
    tick();
    i_Core_Ack = 1'b0; i_Command = CMD_IDLE;
    n_checks++;
    if ({o_Data_Read_Valid, o_Data_Read} !== {1'b1, mem_rd(22'h3FFFFF)})
      $display("FAIL dm_resume_data got valid=%b data=%h want 1 %h", o_Data_Read_Valid, o_Data_Read, mem_rd(22'h3FFFFF));
    else n_pass++;
    last_read = mem_rd(22'h3FFFFF);
    tick();
  endtask

  task automatic test_simultaneous();
    i_Display_Need = 1'b1;
    tick();
    i_Display_Need = 1'b0; i_Command = CMD_READ; i_Data_Address = 22'h000055; i_SDRAM_Yield = 1'b1;
    tick();
    n_checks++;
    if ({o_Display_Grant, o_Core_Req, o_SDRAM_Requested} !== 3'b100)
      $display("FAIL sim_prio got grant=%b req=%b reqflag=%b want 1 0 0", o_Display_Grant, o_Core_Req, o_SDRAM_Requested);
    else n_pass++;
    i_Command = CMD_IDLE; i_SDRAM_Yield = 1'b0;
    tick();
    i_Display_Done = 1'b1;
    tick();
    i_Display_Done = 1'b0;
    n_checks++;
    if ({o_Display_Grant, o_Core_Req, o_Data_Read_Valid} !== 3'b000)
      $display("FAIL sim_release got grant=%b req=%b valid=%b want 0 0 0", o_Display_Grant, o_Core_Req, o_Data_Read_Valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_spurious();
    i_Command = 2'b11; i_Core_Ack = 1'b1; i_Core_Rdata = $urandom; i_Display_Done = 1'b1;
    tick();
    i_Core_Ack = 1'b0; i_Display_Done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({o_Data_Read_Valid, o_Data_Write_Done, o_Core_Req, o_Display_Grant, o_Data_Read} !== {4'b0000, last_read})
        $display("FAIL spur cyc=%0d got valid=%b done=%b req=%b grant=%b data=%h want 0 0 0 0 %h", c,
                 o_Data_Read_Valid, o_Data_Write_Done, o_Core_Req, o_Display_Grant, o_Data_Read, last_read);
      else n_pass++;
      tick();
    end
    i_Command = CMD_READ; i_Data_Address = 22'h000021;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Core_Addr} !== {1'b1, 22'h000021})
      $display("FAIL spur_issue got req=%b addr=%h want 1 000021", o_Core_Req, o_Core_Addr);
    else n_pass++;
    i_Command = CMD_IDLE; i_Core_Ack = 1'b1; i_Core_Rdata = mem_rd(22'h000021);
    tick();
    i_Core_Ack = 1'b0;
    n_checks++;
    if ({o_Data_Read_Valid, o_Data_Read} !== {1'b1, mem_rd(22'h000021)})
      $display("FAIL spur_read got valid=%b data=%h want 1 %h", o_Data_Read_Valid, o_Data_Read, mem_rd(22'h000021));
    else n_pass++;
    last_read = mem_rd(22'h000021);
    tick();
  endtask

  task automatic test_reset_mid_issue();
    i_Command = CMD_WRITE; i_Data_Address = 22'h000077; i_Data_Write = 32'hCAFE_0001;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Core_We} !== 2'b11) $display("FAIL rst_issue got req=%b we=%b want 1 1", o_Core_Req, o_Core_We);
    else n_pass++;
    i_Command = CMD_IDLE;
    #2 i_Reset = 1'b1;
    #1;
    n_checks++;
    if ({o_Core_Req, o_Core_We, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Display_Grant,
         o_Data_Read, o_Core_Addr, o_Core_Wdata} !== '0)
      $display("FAIL rst_async got req=%b we=%b addr=%h wd=%h rd=%h want all 0", o_Core_Req, o_Core_We,
               o_Core_Addr, o_Core_Wdata, o_Data_Read);
    else n_pass++;
    last_read = '0;
    i_Core_Ack = 1'b1;
    tick();
    i_Reset = 1'b0;
    tick();
    i_Core_Ack = 1'b0;
    n_checks++;
    if ({o_Data_Read_Valid, o_Data_Write_Done, o_Core_Req} !== 3'b000)
      $display("FAIL rst_late_ack got valid=%b done=%b req=%b want 0 0 0", o_Data_Read_Valid, o_Data_Write_Done, o_Core_Req);
    else n_pass++;
    i_Command = CMD_READ; i_Data_Address = 22'h000123;
    tick();
    n_checks++;
    if ({o_Core_Req, o_Core_We, o_Core_Addr} !== {1'b1, 1'b0, 22'h000123})
      $display("FAIL rst_after_issue got req=%b we=%b addr=%h want 1 0 000123", o_Core_Req, o_Core_We, o_Core_Addr);
    else n_pass++;
    i_Command = CMD_IDLE; i_Core_Ack = 1'b1; i_Core_Rdata = mem_rd(22'h000123);
    tick();
    i_Core_Ack = 1'b0;
    n_checks++;
    if ({o_Data_Read_Valid, o_Data_Write_Done, o_Data_Read} !== {2'b10, mem_rd(22'h000123)})
      $display("FAIL rst_after_read got valid=%b done=%b data=%h want 1 0 %h", o_Data_Read_Valid,
               o_Data_Write_Done, o_Data_Read, mem_rd(22'h000123));
    else n_pass++;
    last_read = mem_rd(22'h000123);
    tick();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_rd;
    bit iswr;
    int lat;
    for (int w = 0; w < 40; w++) begin
      repeat ($urandom_range(0, 2)) tick();
      iswr = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? 22'h3FFFFF : 22'($urandom_range(0, 7));
      d    = $urandom;
      lat  = $urandom_range(0, 3);
      i_Command = iswr ? CMD_WRITE : CMD_READ; i_Data_Address = a; i_Data_Write = d;
      tick();
      for (int l = 0; l <= lat; l++) begin
        n_checks++;
        if ({o_Core_Req, o_Core_We, o_Core_Addr, o_Core_Wdata, o_Data_Read_Valid, o_Data_Write_Done} !==
            {1'b1, iswr, a, d, 2'b00})
          $display("FAIL rnd_issue word=%0d cyc=%0d got req=%b we=%b addr=%h wd=%h want 1 %b %h %h", w, l,
                   o_Core_Req, o_Core_We, o_Core_Addr, o_Core_Wdata, iswr, a, d);
        else n_pass++;
        if (l < lat) begin
          i_Command = 2'($urandom_range(0, 3)); i_Data_Address = 22'($urandom); i_Data_Write = $urandom;
          tick();
        end
      end
      i_Command = CMD_IDLE; i_Core_Ack = 1'b1;
      if (iswr) begin
        i_Core_Rdata = $urandom; mem[a] = d;
      end else begin
        exp_rd = mem_rd(a); i_Core_Rdata = exp_rd; last_read = exp_rd;
      end
      tick();
      i_Core_Ack = 1'($urandom_range(0, 1));
      n_checks++;
      if ({o_Core_Req, o_Data_Read_Valid, o_Data_Write_Done, o_Data_Read} !== {1'b0, !iswr, iswr, last_read})
        $display("FAIL rnd_done word=%0d got req=%b valid=%b done=%b data=%h want 0 %b %b %h", w, o_Core_Req,
                 o_Data_Read_Valid, o_Data_Write_Done, o_Data_Read, !iswr, iswr, last_read);
      else n_pass++;
      tick();
      i_Core_Ack = 1'b0;
      n_checks++;
      if ({o_Core_Req, o_Data_Read_Valid, o_Data_Write_Done, o_Data_Read} !== {3'b000, last_read})
        $display("FAIL rnd_idle word=%0d got req=%b valid=%b done=%b data=%h want 0 0 0 %h", w, o_Core_Req,
                 o_Data_Read_Valid, o_Data_Write_Done, o_Data_Read, last_read);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_display_mid_burst();
    test_simultaneous();
    test_spurious();
    test_reset_mid_issue();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_client_responder.md
SDRAM_CLIENT_RESPONDER -- requirements
Module: sdram_client_responder

Interface
REQ-001 Parameter ADDR_W, 22, address width of the client command interface and core port.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter CMD_IDLE / CMD_READ / CMD_WRITE, from sdram.vh (2'b00 / 2'b01 / 2'b10); encoding 2'b11 SHALL be treated as CMD_IDLE.
REQ-004 Ports, clock and reset first; one clock; reset is asynchronous and active-high:
- i_Clk  in  1  sole clock
- i_Reset  in  1  asynchronous active-high reset
- i_Command  in  2  client command
- i_Data_Address  in  ADDR_W  client word address
- i_Data_Write  in  DATA_W  client write data
- o_Data_Read  out  DATA_W  read data returned to client
- o_Data_Read_Valid  out  1  one-cycle pulse, one read word delivered
- o_Data_Write_Done  out  1  one-cycle pulse, one write word committed
- o_SDRAM_Requested  out  1  display path wants the bus; client SHALL yield when idle
- i_SDRAM_Yield  in  1  client idle and releasing bus
- o_Core_Req  out  1  word request to SDRAM core, held until ack
- o_Core_We  out  1  1 = write, 0 = read; valid while o_Core_Req
- o_Core_Addr  out  ADDR_W  core word address
- o_Core_Wdata  out  DATA_W  core write data
- i_Core_Ack  in  1  one-cycle core completion; read data valid the same cycle
- i_Core_Rdata  in  DATA_W  core read data
- i_Display_Need  in  1  level, display refill needs the bus
- o_Display_Grant  out  1  display owns the core port
- i_Display_Done  in  1  one-cycle pulse, display releases the bus

Function
REQ-005 FSM states IDLE, ISSUE, GAP, DISP; the FSM SHALL serve one client word per ISSUE visit.
REQ-006 Flag pend SHALL set on any cycle with i_Display_Need=1 and state != DISP, and SHALL clear on the cycle the FSM enters DISP.
REQ-007 o_SDRAM_Requested SHALL equal pend (registered, no combinational path from i_Display_Need).
REQ-008 IDLE: if pend && i_SDRAM_Yield, go to DISP; else if i_Command is READ or WRITE, go to ISSUE; else stay in IDLE.
REQ-009 The display takes priority in IDLE when pend=1 and yield=1 occur in the same cycle as a non-idle command.
REQ-010 On IDLE->ISSUE the block SHALL latch i_Data_Address into o_Core_Addr, i_Data_Write into o_Core_Wdata, and (i_Command==CMD_WRITE) into o_Core_We.
REQ-011 The latched values SHALL hold stable throughout ISSUE, independent of client input changes.
REQ-012 ISSUE: o_Core_Req=1; on i_Core_Ack, go to GAP.
REQ-013 ISSUE completion: on a read, register i_Core_Rdata into o_Data_Read and pulse o_Data_Read_Valid for exactly one cycle, the cycle after the ack.
REQ-014 ISSUE completion: on a write, pulse o_Data_Write_Done for exactly one cycle, the cycle after the ack.
REQ-015 GAP: one cycle with o_Core_Req=0 so the client's address increment and state change propagate, then go to IDLE; minimum client word period is 3 cycles plus core latency.
REQ-016 o_Data_Read SHALL hold its last value until the next read completion.
REQ-017 DISP: o_Display_Grant=1 and o_Core_Req=0; client commands are ignored; on i_Display_Done, go to IDLE.
REQ-018 i_Core_Ack outside ISSUE SHALL be ignored and SHALL produce no valid/done pulse.
REQ-019 A pend set during ISSUE or GAP SHALL NOT abort the word in flight; the handover occurs only when the client yields in IDLE.
REQ-020 i_Display_Done outside DISP SHALL be ignored.
REQ-021 Address handling: client addresses pass through unmodified; no wrap-around or range check in this block.

Reset
REQ-022 Asserting i_Reset SHALL asynchronously force state IDLE, pend=0, and o_Core_Req, o_Core_We, o_Data_Read_Valid, o_Data_Write_Done, o_SDRAM_Requested, o_Display_Grant to 0.
REQ-023 Asserting i_Reset SHALL asynchronously force o_Data_Read, o_Core_Addr, o_Core_Wdata to 0.
REQ-024 Reset mid-ISSUE SHALL drop o_Core_Req immediately with no completion pulse; a late i_Core_Ack after reset SHALL be ignored.
REQ-025 After deassertion, the first client command is accepted on the first rising edge at which the state is IDLE.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- Single read: addr 22'h000010, core acks 2 cycles after req with rdata 32'hDEADBEEF -> o_Core_Addr=0x10, o_Core_We=0, one Read_Valid pulse with o_Data_Read=0xDEADBEEF.
- 8-word write burst (client increments address per Done) -> 8 core writes at addr N..N+7, 8 Done pulses, o_Core_Req low in every GAP cycle.
- Display need raised mid-burst -> o_SDRAM_Requested=1 the next cycle, burst completes, DISP entered only after yield, o_Display_Grant held until Done, then the next client burst is served.
- Simultaneous pend+yield and CMD_READ in IDLE -> DISP chosen, no core req issued.
- Spurious i_Core_Ack in IDLE and spurious i_Display_Done in IDLE -> no pulses, no state change.
- i_Reset asserted while o_Core_Req=1 -> all outputs 0 immediately, no Valid/Done pulse, normal read served after release.
